cfg_bus_initiator: RTL and testbench
====================================

Name: cfg_bus_initiator

Overview:
- Host-side initiator for the accelerator configuration bus and process-start handshake.
- Accepts a queue of commands (register write, register read, start-process) from a host or sequencer and issues them one at a time onto the cfg_* bus.
- Pulses start_process and waits for process_done.
- Returns one response per command, with read data or an error flag.

Parameters:
ADDR_WIDTH, 32, cfg address width
DATA_WIDTH, 32, cfg data width
FIFO_DEPTH, 4, command queue entries; power of 2, ≥2
ACK_TIMEOUT, 16, max WAIT_ACK cycles before error
DONE_TIMEOUT, 1024, max WAIT_DONE cycles; 0 = wait forever

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept (= !full)
cmd_op  in  2  00 write, 01 read, 10 start, 11 reserved
cmd_addr  in  ADDR_WIDTH  register address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  DATA_WIDTH  read data; 0 for write/start/error
rsp_err  out  1  timeout or reserved op
cfg_addr  out  ADDR_WIDTH  bus address
cfg_write  out  1  write strobe
cfg_wdata  out  DATA_WIDTH  bus write data
cfg_read  out  1  read strobe
cfg_rdata  in  DATA_WIDTH  bus read data
cfg_ready  in  1  bus acknowledge
start_process  out  1  process kick pulse
process_done  in  1  process finished (level)
busy  out  1  FSM not IDLE or queue non-empty

Behaviour:
- Reset (async): all outputs 0, except cmd_ready = 1. Queue emptied. FSM in IDLE. Counters cleared. A reset mid-operation drops the strobes immediately; no response is produced.
- Handshakes:
  - A command is accepted on a clk edge where cmd_valid && cmd_ready.
  - A response is retired on an edge where rsp_valid && rsp_ready.
  - rsp_valid, rsp_data and rsp_err stay stable until retired.
- States: IDLE, ISSUE, WAIT_ACK, START, WAIT_DONE, RESP.
- IDLE: if the queue is non-empty, pop the head into command registers.
  - op 00/01 -> ISSUE.
  - op 10 -> START.
  - op 11 -> RESP with err=1.
- ISSUE: exactly one cycle.
  - cfg_addr driven from the command registers.
  - cfg_write=1 (op 00, with cfg_wdata) or cfg_read=1 (op 01).
  - -> WAIT_ACK.
- WAIT_ACK: strobes 0; cfg_addr/cfg_wdata held.
  - cfg_ready=1 -> RESP. On a read, capture cfg_rdata in that same cycle; err=0.
  - ACK_TIMEOUT cycles without cfg_ready -> RESP with err=1, data=0.
  - cfg_ready is sampled only in WAIT_ACK; a late ack is ignored.
- START: start_process=1 for exactly one cycle -> WAIT_DONE. process_done is ignored while start_process=1.
- WAIT_DONE: process_done=1 -> RESP with err=0. DONE_TIMEOUT expiry (if nonzero) -> RESP with err=1.
- RESP: rsp_valid=1; on retire -> IDLE.
- Latency: a write accepted at edge 0 strobes in cycle 2. With a 1-cycle-registered responder, rsp_valid rises in cycle 4.
- Ordering: strictly one command in flight; responses are returned in command order.
- Queue rules:
  - cmd_ready = !full, with no bypass. While full, a simultaneous pop does not allow a push in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Timeout counters saturate and are cleared on every state entry.

Optional Feature:
- Macro: CFG_READBACK_CHECK_EN.
- Defined: after a write acks, the FSM automatically issues a read to the same address (extra ISSUE/WAIT_ACK pass).
  - rsp_err=1 if the readback differs from the written data or the readback times out.
  - rsp_data = readback value.
- Undefined: the write response is issued directly on ack, with rsp_data=0.

Decomposition:
- Package cfg_bus_pkg:
  - cmd_op_t enum (OP_WRITE, OP_READ, OP_START, OP_RSVD).
  - init_state_t enum.
  - cmd struct {op, addr, wdata}.
- Sub-module cmd_fifo: parameterised synchronous FIFO of cmd structs, with push/pop/full/empty.

Test Plan:
- Write 0x1, addr 0x10, data 0xDEADBEEF, responder acks the cycle after the strobe -> cfg_write high exactly cycle 2; rsp_valid cycle 4 with err=0, data=0.
- Write 0xCAFE0001 then read same address -> read response data=0xCAFE0001, err=0; responses arrive in order.
- Read with cfg_ready held 0 -> after 16 WAIT_ACK cycles rsp_err=1, data=0; a late cfg_ready is ignored and the next command proceeds normally.
- Start command, process_done rises 50 cycles later -> start_process is a single-cycle pulse; rsp_valid with err=0 after done; op 11 -> immediate err=1 with no bus strobe.
- Push 6 commands with rsp_ready=0 -> cmd_ready drops after 4 are queued (plus 1 in flight); each response holds until rsp_ready; all 6 complete.
- Assert reset during WAIT_ACK -> all outputs 0 asynchronously; queue empty; no stale response after reset release.

Source files
------------

// File: rtl/cfg_bus_pkg.sv
// rtl/cfg_bus_pkg.sv - Shared types for the cfg bus initiator
package cfg_bus_pkg;

    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_START = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_START,
        S_WAIT_DONE,
        S_RESP
    } init_state_t;

    typedef struct packed {
        cmd_op_t                 op;
        logic [CFG_ADDR_W-1:0]   addr;
        logic [CFG_DATA_W-1:0]   wdata;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - Synchronous command FIFO; full is not relieved by a same-cycle pop
module cmd_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cfg_bus_initiator.sv
// rtl/cfg_bus_initiator.sv - Queued cfg bus initiator with start/done handshake
// Optional write readback verification: CFG_READBACK_CHECK_EN
module cfg_bus_initiator #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int ACK_TIMEOUT  = 16,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic                  cfg_write,
    output logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic                  cfg_read,
    input  logic [DATA_WIDTH-1:0] cfg_rdata,
    input  logic                  cfg_ready,
    output logic                  start_process,
    input  logic                  process_done,
    output logic                  busy
);
    import cfg_bus_pkg::*;

    localparam int          CMD_W     = 2 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] DONE_LAST = 32'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

    logic [CMD_W-1:0]      head;
    logic                  fifo_full, fifo_empty, fifo_pop;
    cmd_op_t               head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    init_state_t           state_q, state_d;
    cmd_op_t               op_q, op_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [DATA_WIDTH-1:0] cfg_wdata_q, cfg_wdata_d;
    logic                  cfg_write_q, cfg_write_d;
    logic                  cfg_read_q, cfg_read_d;
    logic                  start_q, start_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
`ifdef CFG_READBACK_CHECK_EN
    logic                  rb_q, rb_d;
`endif

    cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_addr, cmd_wdata}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_op    = cmd_op_t'(head[CMD_W-1 -: 2]);
    assign head_addr  = head[DATA_WIDTH +: ADDR_WIDTH];
    assign head_wdata = head[DATA_WIDTH-1:0];

    assign cmd_ready     = !fifo_full;
    assign busy          = (state_q != S_IDLE) || !fifo_empty;
    assign cfg_addr      = cfg_addr_q;
    assign cfg_wdata     = cfg_wdata_q;
    assign cfg_write     = cfg_write_q;
    assign cfg_read      = cfg_read_q;
    assign start_process = start_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;

    // Outputs are registered, so each strobe is raised on the edge that enters its state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        cfg_write_d = 1'b0;
        cfg_read_d  = 1'b0;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
`ifdef CFG_READBACK_CHECK_EN
        rb_d        = rb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = head_op;
                    cnt_d    = '0;
                    case (head_op)
                        OP_WRITE, OP_READ: begin
                            state_d     = S_ISSUE;
                            cfg_addr_d  = head_addr;
                            cfg_wdata_d = head_wdata;
                            cfg_write_d = (head_op == OP_WRITE);
                            cfg_read_d  = (head_op == OP_READ);
                        end
                        OP_START: begin
                            state_d = S_START;
                            start_d = 1'b1;
                        end
                        default: begin
                            state_d     = S_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
                cnt_d   = '0;
            end
            S_WAIT_ACK: begin
                if (cfg_ready) begin
`ifdef CFG_READBACK_CHECK_EN
                    if (op_q == OP_WRITE && !rb_q) begin
                        rb_d       = 1'b1;
                        cfg_read_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cfg_rdata;
                        rsp_err_d   = rb_q && (cfg_rdata != cfg_wdata_q);
                    end
`else
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (op_q == OP_READ) ? cfg_rdata : '0;
                    rsp_err_d   = 1'b0;
`endif
                end else if (cnt_q >= ACK_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
                cnt_d   = '0;
            end
            S_WAIT_DONE: begin
                if (process_done || (DONE_TIMEOUT != 0 && cnt_q >= DONE_LAST)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = !process_done;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
`ifdef CFG_READBACK_CHECK_EN
                    rb_d        = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            cnt_q       <= '0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            cfg_write_q <= 1'b0;
            cfg_read_q  <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef CFG_READBACK_CHECK_EN
            rb_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_write_q <= cfg_write_d;
            cfg_read_q  <= cfg_read_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef CFG_READBACK_CHECK_EN
            rb_q        <= rb_d;
`endif
        end
    end

endmodule

// File: tb/tb_cfg_bus_initiator.sv
// tb/tb_cfg_bus_initiator.sv - Self-checking bench for cfg_bus_initiator (default build)
module tb_cfg_bus_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] cfg_addr;
    logic        cfg_write;
    logic [31:0] cfg_wdata;
    logic        cfg_read;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_ready = 1'b0;
    logic        start_process;
    logic        process_done = 1'b0;
    logic        busy;

    cfg_bus_initiator #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4),
        .ACK_TIMEOUT(16), .DONE_TIMEOUT(1024)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cfg_addr(cfg_addr), .cfg_write(cfg_write), .cfg_wdata(cfg_wdata), .cfg_read(cfg_read),
        .cfg_rdata(cfg_rdata), .cfg_ready(cfg_ready),
        .start_process(start_process), .process_done(process_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          tests = 0;
    int          fails = 0;

    // Register-file responder that acks one cycle after a strobe.
    logic [31:0] rmem [256];
    logic        ack_en = 1'b1;
    logic        late_ack = 1'b0;
    int          done_delay = 3;
    int          done_cnt = 0;

    always @(posedge clk) begin
        cfg_ready <= ((cfg_write || cfg_read) && ack_en) || late_ack;
        cfg_rdata <= late_ack ? 32'hBAD0BAD0 : rmem[cfg_addr[9:2]];
        if (cfg_write) rmem[cfg_addr[9:2]] <= cfg_wdata;
    end

    always @(posedge clk) begin
        if (start_process) done_cnt <= done_delay;
        else if (done_cnt > 0) done_cnt <= done_cnt - 1;
        process_done <= (done_cnt == 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: retire against the scoreboard and verify hold stability.
    logic        hold_chk = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_err = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                check("rsp_hold_data", rsp_data, hold_data);
                check("rsp_hold_err", 32'(rsp_err), 32'(hold_err));
            end
            if (rsp_valid) begin
                if (rsp_ready) begin
                    hold_chk = 1'b0;
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end else begin
                    hold_chk  = 1'b1;
                    hold_data = rsp_data;
                    hold_err  = rsp_err;
                end
            end
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input logic exp_err);
        int n = 0;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        sb.push_back('{exp_data, exp_err});
        @(negedge clk);
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("push_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain"}, 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    int          first_wr, first_rd, first_rsp, first_st, n_wr, n_rd, n_st;
    logic [31:0] wr_addr, wr_data;

    // Cycle k is the k-th cycle after the acceptance edge.
    task automatic observe(input int n);
        first_wr = 0; first_rd = 0; first_rsp = 0; first_st = 0;
        n_wr = 0; n_rd = 0; n_st = 0;
        wr_addr = '0; wr_data = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (cfg_write) begin
                if (first_wr == 0) first_wr = k;
                n_wr++;
                wr_addr = cfg_addr;
                wr_data = cfg_wdata;
            end
            if (cfg_read) begin
                if (first_rd == 0) first_rd = k;
                n_rd++;
            end
            if (start_process) begin
                if (first_st == 0) first_st = k;
                n_st++;
            end
            if (rsp_valid && first_rsp == 0) first_rsp = k;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = '0;
        vecs[0] = '{2'b00, 32'h20, 32'hCAFE0001, 32'h0,        1'b0};
        vecs[1] = '{2'b01, 32'h20, 32'h0,        32'hCAFE0001, 1'b0};
        vecs[2] = '{2'b00, 32'h24, 32'h00000055, 32'h0,        1'b0};
        vecs[3] = '{2'b01, 32'h24, 32'h0,        32'h00000055, 1'b0};
        vecs[4] = '{2'b01, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5] = '{2'b11, 32'h28, 32'h12345678, 32'h0,        1'b1};
        vecs[6] = '{2'b10, 32'h0,  32'h0,        32'h0,        1'b0};
        vecs[7] = '{2'b01, 32'h2C, 32'h0,        32'h0,        1'b0};

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_strobes", {29'b0, cfg_write, cfg_read, start_process}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_addr", cfg_addr, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single write: strobe in cycle 2, response in cycle 4.
        push_cmd(2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        observe(8);
        check("wr_first_cycle", first_wr, 2);
        check("wr_strobe_len", n_wr, 1);
        check("wr_addr", wr_addr, 32'h10);
        check("wr_wdata", wr_data, 32'hDEADBEEF);
        check("wr_no_read", n_rd, 0);
        check("wr_rsp_cycle", first_rsp, 4);
        wait_idle("write");

        for (int i = 0; i < 8; i++)
            push_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err);
        wait_idle("table");

        // Reserved op: immediate error, no bus activity.
        push_cmd(2'b11, 32'h40, 32'h1, 32'h0, 1'b1);
        observe(6);
        check("rsvd_rsp_cycle", first_rsp, 2);
        check("rsvd_no_strobe", n_wr + n_rd + n_st, 0);
        wait_idle("rsvd");

        // Ack timeout, late ack while response pending, then normal read.
        rsp_ready = 1'b0;
        ack_en    = 1'b0;
        push_cmd(2'b01, 32'h30, 32'h0, 32'h0, 1'b1);
        observe(24);
        check("to_read_strobe", n_rd, 1);
        check("to_rsp_cycle", first_rsp, 19);
        late_ack = 1'b1;
        @(posedge clk);
        #1 late_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        ack_en    = 1'b1;
        wait_idle("timeout");
        push_cmd(2'b01, 32'h20, 32'h0, 32'hCAFE0001, 1'b0);
        wait_idle("after_timeout");

        // Start/done: one-cycle pulse, response after the done pulse.
        done_delay = 50;
        push_cmd(2'b10, 32'h0, 32'h0, 32'h0, 1'b0);
        observe(70);
        check("start_pulse_len", n_st, 1);
        check("start_cycle", first_st, 2);
        check("start_rsp_cycle", first_rsp, 54);
        check("start_no_bus", n_wr + n_rd, 0);
        wait_idle("start");
        done_delay = 3;

        // Queue fill with responses stalled.
        rsp_ready = 1'b0;
        push_cmd(2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        push_cmd(2'b01, 32'h20, 32'h0, 32'hCAFE0001, 1'b0);
        push_cmd(2'b00, 32'h44, 32'h77, 32'h0, 1'b0);
        push_cmd(2'b01, 32'h44, 32'h0, 32'h77, 1'b0);
        push_cmd(2'b01, 32'h24, 32'h0, 32'h55, 1'b0);
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        fork
            push_cmd(2'b11, 32'h0, 32'h0, 32'h0, 1'b1);
            begin
                repeat (10) @(posedge clk);
                #1;
                check("fill_hold_valid", 32'(rsp_valid), 32'd1);
                rsp_ready = 1'b1;
            end
        join
        wait_idle("fill");

        // Reset while waiting for an ack with another command queued.
        ack_en = 1'b0;
        push_cmd(2'b01, 32'h10, 32'h0, 32'h0, 1'b0);
        push_cmd(2'b00, 32'h48, 32'h99, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_read", 32'(cfg_read), 32'd0);
        check("mid_rst_addr", cfg_addr, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ack_en = 1'b1;
        observe(20);
        check("post_rst_no_rsp", first_rsp, 0);
        check("post_rst_no_bus", n_wr + n_rd, 0);
        check("post_rst_idle", 32'(busy), 32'd0);
        push_cmd(2'b01, 32'h20, 32'h0, 32'hCAFE0001, 1'b0);
        wait_idle("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
